// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: request/response front end for a single-port synchronous SRAM.
// After reset the whole array is cleared (INIT), then requests are forwarded to
// the SRAM through registered strobes and read data is queued in a small FIFO.
// Read acceptance is credit-limited so the response FIFO can never overflow.
// Optional feature: define SRAM_PORT_CTRL_PERF_EN to add rd_count/wr_count.
module sram_port_ctrl #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
`ifdef SRAM_PORT_CTRL_PERF_EN
 ,output logic [15:0]           rd_count
 ,output logic [15:0]           wr_count
`else
`endif
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
  localparam int unsigned PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned OCC_W     = $clog2(RESP_DEPTH + 1);
  localparam int unsigned SUM_W     = OCC_W + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      init_cnt_q, init_cnt_d;

  logic                  csb0_d, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_d;
  logic [DATA_WIDTH-1:0] din0_d;
  logic                  req_ready_d, resp_valid_d, init_done_d;

  logic                  rd_p1_q, rd_p2_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [SUM_W-1:0]      credit_sum_d;
  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];

  logic                  accept, accept_rd, push, pop;

  // Handshake decode; req_ready is only ever high in RUN.
  assign accept    = req_valid & req_ready;
  assign accept_rd = accept & ~req_we;
  assign push      = rd_p2_q;
  assign pop       = resp_valid & resp_ready;

  assign resp_rdata = fifo_mem[rd_ptr_q];

  // Pointer advance modulo RESP_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // FSM state register.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: INIT counts through every address, leaves one edge after the last write.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == CNT_W'(RAM_DEPTH)) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    csb0_d       = 1'b1;
    web0_d       = 1'b1;
    addr0_d      = addr0;
    din0_d       = din0;
    occ_d        = occ_q;
    credit_sum_d = '0;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    init_done_d  = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q != CNT_W'(RAM_DEPTH)) begin
          csb0_d  = 1'b0;
          web0_d  = 1'b0;
          addr0_d = init_cnt_q[ADDR_WIDTH-1:0];
          din0_d  = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          csb0_d  = 1'b0;
          web0_d  = ~req_we;
          addr0_d = req_addr;
          din0_d  = req_wdata;
        end
      end
      default: ;
    endcase

    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end

    // Credit after this edge: reads in both pipe stages plus buffered responses.
    credit_sum_d = SUM_W'(occ_d) + SUM_W'(rd_p1_q) + SUM_W'(accept_rd);
    req_ready_d  = (state_d == ST_RUN) && (credit_sum_d < SUM_W'(RESP_DEPTH));
    resp_valid_d = (occ_d != '0);
    init_done_d  = (state_d == ST_RUN);
  end

  // Output, read-tracking and FIFO control registers.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb0       <= 1'b1;
      web0       <= 1'b1;
      addr0      <= '0;
      din0       <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      init_done  <= 1'b0;
      rd_p1_q    <= 1'b0;
      rd_p2_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      csb0       <= csb0_d;
      web0       <= web0_d;
      addr0      <= addr0_d;
      din0       <= din0_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      init_done  <= init_done_d;
      rd_p1_q    <= accept_rd;
      rd_p2_q    <= rd_p1_q;
      occ_q      <= occ_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Response storage; dout0 is only sampled on a tracked-read capture edge.
  always_ff @(posedge clk0) begin
    if (push) fifo_mem[wr_ptr_q] <= dout0;
  end

`ifdef SRAM_PORT_CTRL_PERF_EN
  // Saturating counters of RUN-state accepted reads and writes.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (accept_rd && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
      if (accept && req_we && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural single-port SRAM model.
module tb_sram_port_ctrl;

  localparam int unsigned DW = 2;
  localparam int unsigned AW = 3;

  logic          clk0 = 1'b0;
  logic          rst0_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic          csb0, web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0, dout0;
`ifdef SRAM_PORT_CTRL_PERF_EN
  logic [15:0]   rd_count, wr_count;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] sram [8] = '{default: 2'b11};

  sram_port_ctrl dut (
    .clk0       (clk0),
    .rst0_n     (rst0_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .csb0       (csb0),
    .web0       (web0),
    .addr0      (addr0),
    .din0       (din0),
    .dout0      (dout0)
`ifdef SRAM_PORT_CTRL_PERF_EN
   ,.rd_count   (rd_count)
   ,.wr_count   (wr_count)
`endif
  );

  always #5 clk0 = ~clk0;

  // SRAM model: samples strobes on the edge, read data valid until the next edge.
  always @(posedge clk0) begin
    if (!csb0 && web0) dout0 <= sram[addr0];
    else               dout0 <= 'x;
    if (!csb0 && !web0) sram[addr0] <= din0;
  end

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  logic [AW-1:0] a29 [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
  logic [DW-1:0] e29 [4] = '{2'b01, 2'b10, 2'b11, 2'b10};

  initial begin
    rst0_n     = 1'b0;
    resp_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0);

    // Reset state
    repeat (2) @(posedge clk0);
    #1;
    chk("rst_csb0",       16'(csb0),       16'd1);
    chk("rst_web0",       16'(web0),       16'd1);
    chk("rst_addr0",      16'(addr0),      16'd0);
    chk("rst_din0",       16'(din0),       16'd0);
    chk("rst_req_ready",  16'(req_ready),  16'd0);
    chk("rst_resp_valid", 16'(resp_valid), 16'd0);
    chk("rst_init_done",  16'(init_done),  16'd0);

    // INIT sweep: eight zero-writes at ascending addresses
    @(negedge clk0);
    rst0_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("init_csb0",      16'(csb0),      16'd0);
      chk("init_web0",      16'(web0),      16'd0);
      chk("init_addr0",     16'(addr0),     16'(i));
      chk("init_din0",      16'(din0),      16'd0);
      chk("init_req_ready", 16'(req_ready), 16'd0);
      chk("init_done_low",  16'(init_done), 16'd0);
    end
    step();
    chk("run_init_done", 16'(init_done), 16'd1);
    chk("run_req_ready", 16'(req_ready), 16'd1);
    chk("run_csb0_idle", 16'(csb0),      16'd1);

    // Back-to-back reads of every address return the cleared value
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'(i), 2'b00);
      step();
      chk("clr_rd_csb0",  16'(csb0),      16'd0);
      chk("clr_rd_web0",  16'(web0),      16'd1);
      chk("clr_rd_ready", 16'(req_ready), 16'd1);
      if (i >= 2) begin
        chk("clr_resp_valid", 16'(resp_valid), 16'd1);
        chk("clr_resp_data",  16'(resp_rdata), 16'd0);
      end
    end
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("clr_tail_valid", 16'(resp_valid), 16'd1);
      chk("clr_tail_data",  16'(resp_rdata), 16'd0);
    end
    step();
    chk("clr_empty", 16'(resp_valid), 16'd0);

    // Write 5 <- 10, then read 5; response two cycles after acceptance
    resp_ready = 1'b0;
    drive(1'b1, 1'b1, 3'd5, 2'b10);
    step();
    chk("wr5_csb0",  16'(csb0),  16'd0);
    chk("wr5_web0",  16'(web0),  16'd0);
    chk("wr5_addr0", 16'(addr0), 16'd5);
    chk("wr5_din0",  16'(din0),  16'd2);
    drive(1'b1, 1'b0, 3'd5, 2'b00);
    step();
    chk("rd5_web0",        16'(web0),       16'd1);
    chk("rd5_no_wr_resp",  16'(resp_valid), 16'd0);
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk("rd5_lat1_valid", 16'(resp_valid), 16'd0);
    chk("idle_csb0",      16'(csb0),       16'd1);
    chk("idle_addr_hold", 16'(addr0),      16'd5);
    step();
    chk("rd5_lat2_valid", 16'(resp_valid), 16'd1);
    chk("rd5_data",       16'(resp_rdata), 16'd2);
    step();
    chk("rd5_hold_valid", 16'(resp_valid), 16'd1);
    chk("rd5_hold_data",  16'(resp_rdata), 16'd2);
    resp_ready = 1'b1;
    step();
    chk("rd5_popped", 16'(resp_valid), 16'd0);

    // Pre-write 1,2,3 then stream reads; one accept per cycle, in-order data
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 3'(i + 1), 2'(i + 1));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'(i + 1), 2'b00);
      step();
      chk("b2b_csb0",  16'(csb0),      16'd0);
      chk("b2b_addr0", 16'(addr0),     16'(i + 1));
      chk("b2b_ready", 16'(req_ready), 16'd1);
    end
    drive(1'b0, 1'b0, '0, '0);
    chk("b2b_r1_valid", 16'(resp_valid), 16'd1);
    chk("b2b_r1_data",  16'(resp_rdata), 16'd1);
    step();
    chk("b2b_r2_data",  16'(resp_rdata), 16'd2);
    step();
    chk("b2b_r3_data",  16'(resp_rdata), 16'd3);
    step();
    chk("b2b_empty",    16'(resp_valid), 16'd0);

    // Backpressure: credits run out after four outstanding reads
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, a29[i], 2'b00);
      step();
      chk("bp_accept_csb0", 16'(csb0),      16'd0);
      chk("bp_ready",       16'(req_ready), (i < 3) ? 16'd1 : 16'd0);
    end
    drive(1'b1, 1'b0, 3'd6, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stall_csb0",  16'(csb0),      16'd1);
      chk("bp_stall_ready", 16'(req_ready), 16'd0);
    end
    chk("bp_full_valid", 16'(resp_valid), 16'd1);
    chk("bp_head_data",  16'(resp_rdata), 16'(e29[0]));
    drive(1'b0, 1'b0, '0, '0);
    resp_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("bp_drain_valid", 16'(resp_valid), 16'd1);
      chk("bp_drain_data",  16'(resp_rdata), 16'(e29[i]));
      chk("bp_drain_ready", 16'(req_ready),  16'd1);
    end
    step();
    chk("bp_drained", 16'(resp_valid), 16'd0);

    // Reset with two reads in flight
    drive(1'b1, 1'b0, 3'd1, 2'b00);
    step();
    drive(1'b1, 1'b0, 3'd2, 2'b00);
    step();
    drive(1'b0, 1'b0, '0, '0);
    rst0_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 16'(resp_valid), 16'd0);
    chk("mid_rst_csb0",       16'(csb0),       16'd1);
    chk("mid_rst_req_ready",  16'(req_ready),  16'd0);
    chk("mid_rst_init_done",  16'(init_done),  16'd0);
    chk("mid_rst_addr0",      16'(addr0),      16'd0);
    repeat (2) step();
    chk("mid_rst_no_stale", 16'(resp_valid), 16'd0);
    @(negedge clk0);
    rst0_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("reinit_csb0",  16'(csb0),       16'd0);
      chk("reinit_addr0", 16'(addr0),      16'(i));
      chk("reinit_valid", 16'(resp_valid), 16'd0);
    end
    step();
    chk("reinit_done",  16'(init_done),  16'd1);
    chk("reinit_valid", 16'(resp_valid), 16'd0);

    // Three writes and two reads after re-init
    drive(1'b1, 1'b1, 3'd0, 2'b11);
    step();
    drive(1'b1, 1'b1, 3'd4, 2'b01);
    step();
    drive(1'b1, 1'b1, 3'd7, 2'b10);
    step();
    drive(1'b1, 1'b0, 3'd4, 2'b00);
    step();
    drive(1'b1, 1'b0, 3'd7, 2'b00);
    step();
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk("fin_r4_data", 16'(resp_rdata), 16'd1);
    step();
    chk("fin_r7_data", 16'(resp_rdata), 16'd2);
`ifdef SRAM_PORT_CTRL_PERF_EN
    chk("perf_wr_count", wr_count, 16'd3);
    chk("perf_rd_count", rd_count, 16'd2);
`endif
    step();
    chk("fin_empty", 16'(resp_valid), 16'd0);

    // Address 5 held 10 before the mid-run reset; re-init must have cleared it
    drive(1'b1, 1'b0, 3'd5, 2'b00);
    step();
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) step();
    chk("reinit_clr_valid", 16'(resp_valid), 16'd1);
    chk("reinit_clr_data",  16'(resp_rdata), 16'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
